// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: data-memory port, lane handling and write-back slot
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_alu_result_i,
    input  logic [XLEN-1:0] ex_rs2_data_i,
    input  logic            ex_is_load_i,
    input  logic            ex_is_store_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            ex_rd_we_i,

    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,

    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [XLEN-1:0] wb_pc_o,
    output logic [XLEN-1:0] wb_rd_data_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic            wb_rd_we_o,
    output logic            wb_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e          state_q, state_d;

    // Context of the memory op in flight
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ea_q, ea_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_we_q, rd_we_d;
    logic [2:0]      f3_q, f3_d;

    // Request registers driven straight onto the memory port
    logic            req_we_q, req_we_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [3:0]      req_be_q, req_be_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;

    // Write-back slot
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_pc_q, wb_pc_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_we_q, wb_we_d;
    logic            wb_fault_q, wb_fault_d;

    logic            accept;
    logic            is_mem;
    logic            f3_ok;
    logic            misaligned;
    logic            mem_fault;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    // Only accept when idle and the slot is empty or draining this cycle
    assign ex_ready_o = (state_q == S_IDLE) && (!wb_valid_q || wb_ready_i);
    assign accept     = ex_valid_i && ex_ready_o;
    assign is_mem     = ex_is_load_i || ex_is_store_i;

    assign dmem_req_o   = (state_q == S_REQ);
    assign dmem_we_o    = req_we_q;
    assign dmem_addr_o  = req_addr_q;
    assign dmem_be_o    = req_be_q;
    assign dmem_wdata_o = req_wdata_q;

    assign wb_valid_o   = wb_valid_q;
    assign wb_pc_o      = wb_pc_q;
    assign wb_rd_data_o = wb_data_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign wb_rd_we_o   = wb_we_q;
    assign wb_fault_o   = wb_fault_q;

    // Decide whether an incoming memory op is illegal or misaligned
    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        if (ex_is_load_i && ex_is_store_i) begin
            f3_ok = 1'b0;
        end else if (ex_is_store_i) begin
            f3_ok = (ex_funct3_i == 3'd0) || (ex_funct3_i == 3'd1) || (ex_funct3_i == 3'd2);
        end else if (ex_is_load_i) begin
            f3_ok = (ex_funct3_i == 3'd0) || (ex_funct3_i == 3'd1) || (ex_funct3_i == 3'd2) ||
                    (ex_funct3_i == 3'd4) || (ex_funct3_i == 3'd5);
        end
        case (ex_funct3_i[1:0])
            2'd1:    misaligned = ex_alu_result_i[0];
            2'd2:    misaligned = |ex_alu_result_i[1:0];
            default: misaligned = 1'b0;
        endcase
        mem_fault = !f3_ok || misaligned;
    end

    // Place store data on its byte lanes; loads read the whole word
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = '0;
        if (ex_is_store_i) begin
            case (ex_funct3_i[1:0])
                2'd0: begin
                    st_be    = 4'b0001 << ex_alu_result_i[1:0];
                    st_wdata = {4{ex_rs2_data_i[7:0]}};
                end
                2'd1: begin
                    st_be    = ex_alu_result_i[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{ex_rs2_data_i[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = ex_rs2_data_i;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        case (ea_q[1:0])
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = ea_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (f3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_data = {24'h000000, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_data = {16'h0000, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // Next-state logic for the FSM, in-flight context and write-back slot
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ea_d        = ea_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        f3_d        = f3_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_be_d    = req_be_q;
        req_wdata_d = req_wdata_q;
        wb_valid_d  = wb_valid_q && !wb_ready_i;
        wb_pc_d     = wb_pc_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        wb_fault_d  = wb_fault_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_mem || mem_fault) begin
                        // ALU results and faulting memory ops go straight to the slot
                        wb_valid_d = 1'b1;
                        wb_pc_d    = ex_pc_i;
                        wb_data_d  = ex_alu_result_i;
                        wb_rd_d    = ex_rd_addr_i;
                        wb_we_d    = ex_rd_we_i && (ex_rd_addr_i != 5'd0) && !is_mem;
                        wb_fault_d = is_mem;
                    end else begin
                        pc_d        = ex_pc_i;
                        ea_d        = ex_alu_result_i;
                        rd_d        = ex_rd_addr_i;
                        rd_we_d     = ex_rd_we_i;
                        f3_d        = ex_funct3_i;
                        req_we_d    = ex_is_store_i;
                        req_addr_d  = {ex_alu_result_i[XLEN-1:2], 2'b00};
                        req_be_d    = st_be;
                        req_wdata_d = st_wdata;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    if (req_we_q) begin
                        // Stores retire on grant; nothing is written back
                        wb_valid_d = 1'b1;
                        wb_pc_d    = pc_q;
                        wb_data_d  = ea_q;
                        wb_rd_d    = rd_q;
                        wb_we_d    = 1'b0;
                        wb_fault_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_q;
                    wb_data_d  = ld_data;
                    wb_rd_d    = rd_q;
                    wb_we_d    = rd_we_q && (rd_q != 5'd0);
                    wb_fault_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any request in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ea_q        <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            f3_q        <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= '0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            wb_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ea_q        <= ea_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            f3_q        <= f3_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            wb_fault_q  <= wb_fault_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [31:0] ex_pc_i = '0;
    logic [31:0] ex_alu_result_i = '0;
    logic [31:0] ex_rs2_data_i = '0;
    logic        ex_is_load_i = 1'b0;
    logic        ex_is_store_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic [4:0]  ex_rd_addr_i = '0;
    logic        ex_rd_we_i = 1'b0;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic [31:0] wb_pc_o;
    logic [31:0] wb_rd_data_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_rd_we_o;
    logic        wb_fault_o;

    mem_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_pc_i(ex_pc_i),
        .ex_alu_result_i(ex_alu_result_i), .ex_rs2_data_i(ex_rs2_data_i),
        .ex_is_load_i(ex_is_load_i), .ex_is_store_i(ex_is_store_i), .ex_funct3_i(ex_funct3_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_pc_o(wb_pc_o),
        .wb_rd_data_o(wb_rd_data_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_we_o(wb_rd_we_o),
        .wb_fault_o(wb_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        fault;
        int          lat;
        int          acc;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } dm_exp_t;

    wb_exp_t wb_q[$];
    dm_exp_t dm_q[$];
    int      pop_cyc[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic [31:0] rdata_cfg = '0;
    int          gnt_cyc = 0;
    int          req_len = 0;
    int          resp_age = 0;
    int          resp_rv = -1;
    dm_exp_t     resp_cur;
    wb_exp_t     mon_e;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] pc, data, input logic [4:0] rd,
                           input logic we, fault, input int lat);
        wb_q.push_back('{pc, data, rd, we, fault, lat, cyc});
    endtask

    task automatic dm_expect(input logic [31:0] addr, input logic [3:0] be,
                             input logic we, input logic [31:0] wdata);
        dm_q.push_back('{addr, wdata, be, we});
    endtask

    task automatic issue(input logic [31:0] pc, alu, rs2, input logic ld, st,
                         input logic [2:0] f3, input logic [4:0] rd, input logic we,
                         input logic [31:0] exp_data, input logic exp_we, exp_fault,
                         input int lat, input bit sb);
        int n;
        n = 0;
        ex_pc_i = pc; ex_alu_result_i = alu; ex_rs2_data_i = rs2;
        ex_is_load_i = ld; ex_is_store_i = st; ex_funct3_i = f3;
        ex_rd_addr_i = rd; ex_rd_we_i = we; ex_valid_i = 1'b1;
        @(negedge clk_i);
        while (!ex_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!ex_ready_o) begin
            check("accept_timeout", 32'd0, 32'd1);
            ex_valid_i = 1'b0;
            return;
        end
        if (sb) sb_push(pc, exp_data, rd, exp_we, exp_fault, lat);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (wb_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (wb_q.size() != 0) begin
            check("drain_timeout", wb_q.size(), 0);
            wb_q.delete();
        end
        @(posedge clk_i); #1;
    endtask

    // Write-back monitor: pops the scoreboard on every slot handshake
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && wb_valid_o && wb_ready_i) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    mon_e = wb_q.pop_front();
                    check("wb_pc", wb_pc_o, mon_e.pc);
                    check("wb_data", wb_rd_data_o, mon_e.data);
                    check("wb_rd", {27'd0, wb_rd_addr_o}, {27'd0, mon_e.rd});
                    check("wb_we", {31'd0, wb_rd_we_o}, {31'd0, mon_e.we});
                    check("wb_fault", {31'd0, wb_fault_o}, {31'd0, mon_e.fault});
                    if (mon_e.lat > 0) check("wb_latency", cyc - mon_e.acc, mon_e.lat);
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    // Data-memory responder with programmable grant and rvalid delays
    initial begin
        forever begin
            @(posedge clk_i); #1;
            dmem_gnt_i = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (resp_rv == 0) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i = rdata_cfg;
                resp_rv = -1;
            end else if (resp_rv > 0) begin
                resp_rv--;
            end
            if (dmem_req_o) begin
                check("ready_in_req", {31'd0, ex_ready_o}, 32'd0);
                if (resp_age == 0) begin
                    req_len = 1;
                    if (dm_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                        resp_cur = '{dmem_addr_o, dmem_wdata_o, dmem_be_o, dmem_we_o};
                    end else begin
                        resp_cur = dm_q.pop_front();
                    end
                end else begin
                    req_len++;
                end
                check("req_addr", dmem_addr_o, resp_cur.addr);
                check("req_be", {28'd0, dmem_be_o}, {28'd0, resp_cur.be});
                check("req_we", {31'd0, dmem_we_o}, {31'd0, resp_cur.we});
                if (resp_cur.we) check("req_wdata", dmem_wdata_o, resp_cur.wdata);
                if (resp_age == gnt_delay) begin
                    dmem_gnt_i = 1'b1;
                    gnt_cyc = cyc;
                    resp_age = 0;
                    if (!resp_cur.we) resp_rv = rv_delay;
                end else begin
                    resp_age++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("rst_wb_pc", wb_pc_o, 32'd0);
        check("rst_wb_data", wb_rd_data_o, 32'd0);
        check("rst_wb_misc", {29'd0, wb_rd_we_o, wb_fault_o, |wb_rd_addr_o}, 32'd0);
        check("rst_dmem_ctl", {30'd0, dmem_req_o, dmem_we_o}, 32'd0);
        check("rst_dmem_addr", dmem_addr_o, 32'd0);
        check("rst_dmem_be", {28'd0, dmem_be_o}, 32'd0);
        check("rst_dmem_wdata", dmem_wdata_o, 32'd0);
        check("rst_ex_ready", {31'd0, ex_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Back-to-back ALU ops, then an rd=0 op
        pop_cyc.delete();
        for (int i = 0; i < 4; i++)
            issue(32'h1000 + 32'(4 * i), 32'h11 * 32'(i + 1), 32'h0, 1'b0, 1'b0, 3'd0,
                  5'(i + 1), 1'b1, 32'h11 * 32'(i + 1), 1'b1, 1'b0, 1, 1'b1);
        issue(32'h1010, 32'h55, 32'h0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 32'h55, 1'b0, 1'b0, 1, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) check("alu_back_to_back", pop_cyc[i + 1] - pop_cyc[i], 1);

        // SB to 0x103 with grant delayed 3 cycles
        gnt_delay = 3;
        dm_expect(32'h100, 4'b1000, 1'b1, 32'hA5A5A5A5);
        issue(32'h2000, 32'h103, 32'hA5, 1'b0, 1'b1, 3'd0, 5'd5, 1'b1, 32'h103, 1'b0, 1'b0, 5, 1'b1);
        drain();
        check("sb_req_held_cycles", req_len, 4);
        check("sb_wb_after_gnt", pop_cyc[pop_cyc.size() - 1] - gnt_cyc, 1);

        // Other stores with immediate grant
        gnt_delay = 0;
        dm_expect(32'h200, 4'b1100, 1'b1, 32'hABCDABCD);
        issue(32'h2004, 32'h202, 32'h1234ABCD, 1'b0, 1'b1, 3'd1, 5'd6, 1'b1, 32'h202, 1'b0, 1'b0, 2, 1'b1);
        dm_expect(32'h204, 4'b1111, 1'b1, 32'hCAFEBABE);
        issue(32'h2008, 32'h204, 32'hCAFEBABE, 1'b0, 1'b1, 3'd2, 5'd6, 1'b1, 32'h204, 1'b0, 1'b0, 2, 1'b1);
        dm_expect(32'h100, 4'b0001, 1'b1, 32'hFFFFFFFF);
        issue(32'h200C, 32'h100, 32'h1FF, 1'b0, 1'b1, 3'd0, 5'd6, 1'b1, 32'h100, 1'b0, 1'b0, 2, 1'b1);
        drain();

        // Loads with lane select and extension
        rv_delay = 0;
        rdata_cfg = 32'h00F00000;
        dm_expect(32'h100, 4'hF, 1'b0, 32'h0);
        issue(32'h3000, 32'h102, 32'h0, 1'b1, 1'b0, 3'd0, 5'd5, 1'b1, 32'hFFFFFFF0, 1'b1, 1'b0, 3, 1'b1);
        drain();
        dm_expect(32'h100, 4'hF, 1'b0, 32'h0);
        issue(32'h3004, 32'h102, 32'h0, 1'b1, 1'b0, 3'd4, 5'd5, 1'b1, 32'h000000F0, 1'b1, 1'b0, 3, 1'b1);
        drain();
        rdata_cfg = 32'h80000000;
        dm_expect(32'h100, 4'hF, 1'b0, 32'h0);
        issue(32'h3008, 32'h102, 32'h0, 1'b1, 1'b0, 3'd1, 5'd7, 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 3, 1'b1);
        drain();
        dm_expect(32'h100, 4'hF, 1'b0, 32'h0);
        issue(32'h300C, 32'h102, 32'h0, 1'b1, 1'b0, 3'd5, 5'd7, 1'b1, 32'h00008000, 1'b1, 1'b0, 3, 1'b1);
        drain();
        rdata_cfg = 32'hDEADBEEF;
        dm_expect(32'h104, 4'hF, 1'b0, 32'h0);
        issue(32'h3010, 32'h104, 32'h0, 1'b1, 1'b0, 3'd2, 5'd8, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b1);
        drain();
        rdata_cfg = 32'h00007F00;
        dm_expect(32'h100, 4'hF, 1'b0, 32'h0);
        issue(32'h3014, 32'h101, 32'h0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b1, 32'h0000007F, 1'b0, 1'b0, 3, 1'b1);
        drain();

        // Faults: no memory request, slot loaded one cycle after accept
        issue(32'h4000, 32'h101, 32'h0, 1'b1, 1'b0, 3'd2, 5'd9, 1'b1, 32'h101, 1'b0, 1'b1, 1, 1'b1);
        issue(32'h4004, 32'h203, 32'h1234, 1'b0, 1'b1, 3'd1, 5'd9, 1'b1, 32'h203, 1'b0, 1'b1, 1, 1'b1);
        issue(32'h4008, 32'h400, 32'h0, 1'b1, 1'b1, 3'd0, 5'd9, 1'b1, 32'h400, 1'b0, 1'b1, 1, 1'b1);
        issue(32'h400C, 32'h400, 32'h0, 1'b1, 1'b0, 3'd3, 5'd9, 1'b1, 32'h400, 1'b0, 1'b1, 1, 1'b1);
        issue(32'h4010, 32'h400, 32'h0, 1'b0, 1'b1, 3'd4, 5'd9, 1'b1, 32'h400, 1'b0, 1'b1, 1, 1'b1);
        drain();

        // Backpressure: slot full for 5 cycles with another op pending
        wb_ready_i = 1'b0;
        issue(32'h5000, 32'h77, 32'h0, 1'b0, 1'b0, 3'd0, 5'd7, 1'b1, 32'h77, 1'b1, 1'b0, 0, 1'b1);
        ex_pc_i = 32'h5004; ex_alu_result_i = 32'h88; ex_is_load_i = 1'b0; ex_is_store_i = 1'b0;
        ex_funct3_i = 3'd0; ex_rd_addr_i = 5'd8; ex_rd_we_i = 1'b1; ex_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_ex_ready", {31'd0, ex_ready_o}, 32'd0);
            check("bp_wb_valid", {31'd0, wb_valid_o}, 32'd1);
            check("bp_wb_pc", wb_pc_o, 32'h5000);
            check("bp_wb_data", wb_rd_data_o, 32'h77);
            check("bp_wb_rd", {27'd0, wb_rd_addr_o}, 32'd7);
        end
        @(posedge clk_i); #1;
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_same_cycle_accept", {31'd0, ex_ready_o}, 32'd1);
        sb_push(32'h5004, 32'h88, 5'd8, 1'b1, 1'b0, 1);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
        drain();

        // Reset while waiting for read data; rvalid arrives right after reset
        gnt_delay = 0;
        rv_delay = 1;
        rdata_cfg = 32'hCAFEF00D;
        dm_expect(32'h300, 4'hF, 1'b0, 32'h0);
        issue(32'h6000, 32'h300, 32'h0, 1'b1, 1'b0, 3'd2, 5'd9, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        n = 0;
        seen = 1'b0;
        while (n < 50) begin
            if (dmem_req_o) seen = 1'b1;
            else if (seen) break;
            @(posedge clk_i); #1;
            n++;
        end
        check("rst_wait_req_seen", {31'd0, seen}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("midrst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
            check("midrst_ex_ready", {31'd0, ex_ready_o}, 32'd1);
            check("midrst_req", {31'd0, dmem_req_o}, 32'd0);
        end
        @(posedge clk_i); #1;

        // Stage is usable again after reset
        issue(32'h7000, 32'h99, 32'h0, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1, 32'h99, 1'b1, 1'b0, 1, 1'b1);
        drain();

        check("wb_queue_empty", wb_q.size(), 0);
        check("dmem_queue_empty", dm_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I pipeline, directly downstream of execute and upstream of write-back. It accepts one execute result per handshake. Loads and stores go to a request/grant/response data-memory port with byte lanes and sign/zero extension. Non-memory results pass to write-back through a single registered output slot.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- ex_valid_i  in  1  execute result valid.
- ex_ready_o  out  1  stage can accept; a transfer occurs when ex_valid_i && ex_ready_o.
- ex_pc_i  in  XLEN  PC of the instruction.
- ex_alu_result_i  in  XLEN  ALU result, or effective address for a load/store.
- ex_rs2_data_i  in  XLEN  store data.
- ex_is_load_i / ex_is_store_i  in  1 each  memory-op class; both high is illegal.
- ex_funct3_i  in  3  RV32I load/store funct3.
- ex_rd_addr_i  in  5  destination register.
- ex_rd_we_i  in  1  destination write enable.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  XLEN  word-aligned address, addr[1:0] = 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  lane-aligned store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid, 1 cycle after grant at the earliest.
- dmem_rdata_i  in  XLEN  read word.
- wb_valid_o  out  1  write-back slot valid.
- wb_ready_i  in  1  write-back consumes the slot.
- wb_pc_o, wb_rd_data_o  out  XLEN each  PC and result.
- wb_rd_addr_o  out  5  destination register.
- wb_rd_we_o  out  1  write enable.
- wb_fault_o  out  1  misaligned or illegal memory op; no write, no memory access.

## Operation
- FSM states:
  - IDLE: no memory op in flight.
  - REQ: dmem_req_o = 1; waiting for grant.
  - WAIT: waiting for dmem_rvalid_i.
- Output slot: one register set holding wb_valid_o, wb_pc_o, wb_rd_data_o, wb_rd_addr_o, wb_rd_we_o and wb_fault_o.
- ex_ready_o = (state == IDLE) && (!wb_valid_o || wb_ready_i). This is combinational on wb_ready_i.
- Accepted non-memory op: loaded into the slot with rd_data = alu_result.
- Fault check on an accepted memory op:
  - funct3 legal for loads: 0, 1, 2, 4, 5. For stores: 0, 1, 2.
  - Alignment: halfword needs addr[0] = 0; word needs addr[1:0] = 0.
  - On fault: no request is issued. The slot is loaded with wb_fault_o = 1, wb_rd_we_o = 0, rd_data = the address.
- Accepted legal memory op:
  - Latches pc, rd, funct3, addr[1:0], dmem_addr = {addr[31:2], 2'b00}, be and wdata.
  - Goes to REQ.
- Store encoding:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); wdata = halfword replicated ×2.
  - SW: be = 1111.
- Loads: dmem_we_o = 0, be = 1111.
- REQ: on dmem_gnt_i:
  - Store: load the slot (rd_we = 0, rd_data = address) and go to IDLE.
  - Load: go to WAIT.
- WAIT: on dmem_rvalid_i, select the lane, extend, load the slot, go to IDLE.
  - LB/LBU: byte rdata[8·addr[1:0] +: 8], sign-/zero-extended.
  - LH/LHU: half rdata[16·addr[1] +: 16], sign-/zero-extended.
  - LW: full word.
- The slot is never occupied when a memory op completes, because acceptance requires the slot to drain.
- The slot clears (wb_valid_o → 0) on wb_ready_i unless a new accept refills it in the same cycle.
- wb_rd_we_o = ex_rd_we_i && (rd_addr != 0) && !fault. Stores always give 0.
- dmem_rvalid_i outside WAIT is ignored. dmem_gnt_i outside REQ is ignored.
- ex_is_load_i && ex_is_store_i: treated as a fault.

## Timing
- Reset values:
  - state = IDLE.
  - All wb_* outputs = 0.
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o = 0.
  - ex_ready_o = 1 combinationally while idle with the slot empty.
- Reset mid-transaction: the request is dropped and the FSM returns to IDLE. A late rvalid after reset is ignored.
- Non-memory op and fault: wb_valid_o rises 1 cycle after accept. With wb_ready_i held at 1, throughput is 1 per cycle.
- Memory request timing: dmem_req_o rises the cycle after accept. dmem_addr_o, be, we and wdata hold stable from then until the grant cycle.
- Store: wb_valid_o rises 1 cycle after the grant. Minimum 2 cycles accept→wb_valid.
- Load: wb_valid_o rises 1 cycle after rvalid. Minimum 3 cycles accept→wb_valid.
- dmem_req_o falls the cycle after grant.
- ex_ready_o = 0 throughout REQ/WAIT, and while the slot is full with wb_ready_i = 0.
- Slot outputs hold stable while wb_valid_o && !wb_ready_i.

## Test plan
- ALU stream: 4 back-to-back non-memory ops (rd = 1..4, results 0x11..0x44), wb_ready_i = 1 → wb_valid_o for 4 consecutive cycles, in order. rd = 0 op → wb_rd_we_o = 0.
- SB x2 to 0x103 with rs2 = 0xA5, grant delayed 3 cycles → dmem_addr_o = 0x100, be = 1000, wdata = 0xA5A5A5A5, all held for 4 cycles. wb_valid_o rises 1 cycle after grant with rd_we = 0.
- LB and LBU at 0x102, rdata = 0x00F00000 → rd_data = 0xFFFFFFF0 and 0x000000F0. LH at 0x102 with rdata = 0x80000000 → 0xFFFF8000. LW → raw word.
- LW at 0x101 and SH at 0x203 → no dmem_req_o; wb_fault_o = 1, wb_rd_we_o = 0, one cycle after accept.
- Backpressure: wb_ready_i = 0 for 5 cycles with the slot full → ex_ready_o = 0 and wb_* stable. When wb_ready_i rises, the pending op is accepted in that same cycle.
- rst_i asserted in WAIT, then rvalid pulses the cycle after → state IDLE, wb_valid_o = 0, rvalid ignored.
